ws2812_frame_driver: RTL and testbench

- Downstream stage of led_color_fader; consumes its 24-bit cor_out (RGB, R in [23:16]) and drives the single-wire WS2812 LED chain data pin.
- Latches the color once per frame so a fader update mid-frame never tears a frame.
- Serialises the color to every LED in the chain, then holds the latch (reset) gap.
- Refreshes continuously while enabled.

---
 rtl/ws2812_pkg.sv | 23 ++
 rtl/ws2812_frame_driver_if.sv | 11 +
 rtl/ws2812_bit_encoder.sv | 47 ++++
 rtl/ws2812_frame_driver.sv | 118 +++++++++++
 tb/tb_ws2812_frame_driver.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// Shared types, default 50 MHz timing and the GRB reorder helper for the WS2812 frame driver.
package ws2812_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_t;

    localparam int DEF_NUM_LEDS = 8;
    localparam int DEF_T0H      = 20;
    localparam int DEF_T1H      = 40;
    localparam int DEF_TBIT     = 63;
    localparam int DEF_TRESET   = 2600;

    // WS2812 parts shift green first, so the fader's RGB word is rearranged to GRB.
    function automatic logic [23:0] grb_reorder(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_frame_driver_if.sv
// Colour/enable in, LED data line and frame status out, for the WS2812 frame driver.
interface ws2812_frame_driver_if;
    logic        enable;
    logic [23:0] cor_in;
    logic        dout;
    logic        busy;
    logic        frame_done;

    modport master (output enable, output cor_in, input dout, input busy, input frame_done);
    modport slave  (input enable, input cor_in, output dout, output busy, output frame_done);
endinterface

// File: rtl/ws2812_bit_encoder.sv
// Produces one WS2812 bit waveform per start pulse; bit_val is read live throughout the bit.
module ws2812_bit_encoder #(
    parameter int T0H  = 20,
    parameter int T1H  = 40,
    parameter int TBIT = 63
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic dout,
    output logic high_done,
    output logic bit_done
);
    localparam int CW = $clog2(TBIT + 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [CW-1:0] high_time;

    assign high_time = bit_val ? CW'(T1H) : CW'(T0H);
    assign high_done = active && (cnt == high_time - CW'(1));
    assign bit_done  = active && (cnt == CW'(TBIT - 1));

    // A start on the last cycle of a bit chains the next bit with no gap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            dout   <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            dout   <= 1'b1;
        end else if (active) begin
            if (cnt == CW'(TBIT - 1)) begin
                active <= 1'b0;
                cnt    <= '0;
                dout   <= 1'b0;
            end else begin
                cnt  <= cnt + CW'(1);
                dout <= (cnt + CW'(1)) < high_time;
            end
        end
    end

endmodule

// File: rtl/ws2812_frame_driver.sv
// Latches one colour per frame and streams it to every LED, followed by the latch gap.
module ws2812_frame_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int TBIT     = DEF_TBIT,
    parameter int TRESET   = DEF_TRESET
) (
    input logic clock,
    input logic reset,
    ws2812_frame_driver_if.slave bus
);
    localparam int MAXP = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int PW   = $clog2(MAXP + 1);
    localparam int LW   = $clog2(NUM_LEDS + 1);

    state_t        state;
    logic [23:0]   shadow;
    logic [4:0]    bit_idx;
    logic [LW-1:0] led_cnt;
    logic [PW-1:0] latch_cnt;
    logic          busy_q;
    logic          frame_done_q;

    logic enc_start;
    logic enc_dout;
    logic high_done;
    logic bit_done;
    logic last_bit;

    assign last_bit  = (bit_idx == 5'd0) && (led_cnt == LW'(NUM_LEDS - 1));
    assign enc_start = (state == ST_LOAD) || ((state == ST_LOW) && bit_done && !last_bit);

    ws2812_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_encoder (
        .clock     (clock),
        .reset     (reset),
        .start     (enc_start),
        .bit_val   (shadow[bit_idx]),
        .dout      (enc_dout),
        .high_done (high_done),
        .bit_done  (bit_done)
    );

    assign bus.dout       = enc_dout;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            shadow       <= '0;
            bit_idx      <= '0;
            led_cnt      <= '0;
            latch_cnt    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state  <= ST_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    shadow  <= grb_reorder(bus.cor_in);
                    bit_idx <= 5'd23;
                    led_cnt <= '0;
                    state   <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (high_done) state <= ST_LOW;
                end
                ST_LOW: begin
                    if (bit_done) begin
                        if (bit_idx != 5'd0) begin
                            bit_idx <= bit_idx - 5'd1;
                            state   <= ST_HIGH;
                        end else if (!last_bit) begin
                            // Every LED in the chain gets the same shadowed colour.
                            led_cnt <= led_cnt + LW'(1);
                            bit_idx <= 5'd23;
                            state   <= ST_HIGH;
                        end else begin
                            latch_cnt    <= '0;
                            frame_done_q <= (TRESET == 1);
                            state        <= ST_LATCH;
                        end
                    end
                end
                ST_LATCH: begin
                    latch_cnt <= latch_cnt + PW'(1);
                    if (latch_cnt == PW'(TRESET - 2)) frame_done_q <= 1'b1;
                    if (latch_cnt == PW'(TRESET - 1)) begin
                        if (bus.enable) begin
                            state <= ST_LOAD;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Scoreboard bench: stimulus queues expected GRB words, a monitor decodes dout and checks framing.
module tb_ws2812_frame_driver;
    localparam int NUM_LEDS = 2;
    localparam int T0H      = 2;
    localparam int T1H      = 4;
    localparam int TBIT     = 6;
    localparam int TRESET   = 10;
    localparam int FRAME    = 1 + NUM_LEDS * 24 * TBIT + TRESET;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ws2812_frame_driver_if bus();

    ws2812_frame_driver #(
        .NUM_LEDS (NUM_LEDS),
        .T0H      (T0H),
        .T1H      (T1H),
        .TBIT     (TBIT),
        .TRESET   (TRESET)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [23:0] exp_q[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [23:0] cor);
        bus.enable = en;
        bus.cor_in = cor;
    endtask

    task automatic waitFrameDone(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!bus.frame_done && cycles < 1000);
        if (!bus.frame_done) begin
            total++;
            bad++;
            $display("[TB] FAIL frame_done_timeout: got none expected pulse within %0d cycles", cycles);
        end
    endtask

    // Monitor state: decodes each high pulse into a bit and assembles 24-bit words.
    logic        prev_dout, prev_busy, prev_fd, bitv;
    logic [23:0] word, exp_word;
    int          nbits, words, frame_cyc, period_cnt, high_cnt;
    bit          in_frame;

    always @(negedge clock) begin
        if (reset) begin
            prev_dout = 1'b0; prev_busy = 1'b0; prev_fd = 1'b0;
            nbits = 0; words = 0; frame_cyc = 0; period_cnt = 0; high_cnt = 0;
            in_frame = 1'b0; word = '0;
        end else begin
            if (bus.busy && (!prev_busy || prev_fd)) begin
                frame_cyc = 0;
                words     = 0;
            end else begin
                frame_cyc++;
            end
            if (bus.dout && !prev_dout) begin
                if (in_frame) checkOutput("bit_period", period_cnt, TBIT);
                period_cnt = 1;
                high_cnt   = 1;
            end else begin
                period_cnt++;
                if (bus.dout) high_cnt++;
            end
            if (!bus.dout && prev_dout) begin
                total++;
                if (high_cnt != T0H && high_cnt != T1H) begin
                    bad++;
                    $display("[TB] FAIL pulse_width: got %0d expected %0d or %0d", high_cnt, T0H, T1H);
                end
                bitv     = (high_cnt == T1H);
                word     = {word[22:0], bitv};
                in_frame = 1'b1;
                nbits++;
                if (nbits == 24) begin
                    nbits = 0;
                    words++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL led_word: got %06h expected nothing queued", word);
                    end else begin
                        exp_word = exp_q.pop_front();
                        if (word !== exp_word) begin
                            bad++;
                            $display("[TB] FAIL led_word: got %06h expected %06h", word, exp_word);
                        end
                    end
                end
            end
            if (bus.frame_done) begin
                checkOutput("frame_len", frame_cyc, FRAME - 1);
                checkOutput("leds_per_frame", words, NUM_LEDS);
                checkOutput("partial_bits", nbits, 0);
                in_frame = 1'b0;
            end
            prev_dout = bus.dout;
            prev_busy = bus.busy;
            prev_fd   = bus.frame_done;
        end
    end

    initial begin
        int c;
        applyStimulus(1'b0, 24'h000000);

        // Reset held with the clock running.
        repeat (3) @(negedge clock);
        checkOutput("reset_dout", bus.dout, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_frame_done", bus.frame_done, 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checkOutput("idle_dout", bus.dout, 0);
        end
        checkOutput("idle_busy", bus.busy, 0);

        // Single red frame from a one-cycle enable.
        applyStimulus(1'b1, 24'hFF0000);
        exp_q.push_back(24'h00FF00);
        exp_q.push_back(24'h00FF00);
        @(negedge clock);
        checkOutput("red_busy_rise", bus.busy, 1);
        applyStimulus(1'b0, 24'hFF0000);
        waitFrameDone(c);
        checkOutput("red_frame_done_at", c, FRAME - 1);
        @(negedge clock);
        checkOutput("red_idle_busy", bus.busy, 0);
        checkOutput("red_idle_dout", bus.dout, 0);

        // Tear-free latch, then continuous back-to-back frames.
        applyStimulus(1'b1, 24'h0000FF);
        exp_q.push_back(24'h0000FF);
        exp_q.push_back(24'h0000FF);
        @(negedge clock);
        checkOutput("blue_busy_rise", bus.busy, 1);
        repeat (50) @(negedge clock);
        applyStimulus(1'b1, 24'hFFFFFF);
        exp_q.push_back(24'hFFFFFF);
        exp_q.push_back(24'hFFFFFF);
        waitFrameDone(c);
        @(negedge clock);
        checkOutput("cont_no_idle_busy", bus.busy, 1);
        checkOutput("cont_no_idle_dout", bus.dout, 0);
        exp_q.push_back(24'hFFFFFF);
        exp_q.push_back(24'hFFFFFF);
        waitFrameDone(c);
        checkOutput("cont_period", c + 1, FRAME);

        // Third frame: enable dropped at frame cycle 100.
        @(negedge clock);
        checkOutput("cont2_no_idle_busy", bus.busy, 1);
        repeat (100) @(negedge clock);
        applyStimulus(1'b0, 24'hFFFFFF);
        waitFrameDone(c);
        checkOutput("early_disable_len", c + 100, FRAME - 1);
        @(negedge clock);
        checkOutput("early_disable_busy", bus.busy, 0);
        checkOutput("early_disable_dout", bus.dout, 0);
        repeat (5) @(negedge clock);
        checkOutput("early_disable_stays_idle", bus.busy, 0);

        // Asynchronous reset while dout is high.
        applyStimulus(1'b1, 24'h123456);
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!bus.dout && c < 20);
        checkOutput("pre_reset_dout_high", bus.dout, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_dout", bus.dout, 0);
        checkOutput("async_reset_busy", bus.busy, 0);
        checkOutput("async_reset_frame_done", bus.frame_done, 0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        applyStimulus(1'b1, 24'h00FF80);
        exp_q.push_back(24'hFF0080);
        exp_q.push_back(24'hFF0080);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("restart_busy", bus.busy, 1);
        applyStimulus(1'b0, 24'h00FF80);
        waitFrameDone(c);
        checkOutput("restart_frame_done_at", c, FRAME - 1);
        @(negedge clock);
        checkOutput("restart_idle_busy", bus.busy, 0);

        repeat (3) @(negedge clock);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
